// File: rtl/sd_emmc_rx_deser.sv
// SD/eMMC receive deserialiser: takes per-lane rise/fall samples from the DDR
// capture stage, finds the start bit, packs data bits into bytes, skips CRC and
// checks the end bit on the active lanes.
//
// state        | meaning
// S_IDLE       | waiting for arm; configuration checked here
// S_WAIT_START | watching lane 0 for the start bit, timeout running
// S_DATA       | assembling data bytes
// S_CRC        | 16 CRC cycles discarded
// S_END        | end bit sampled on the active lanes
module sd_emmc_rx_deser #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_W      = 12,
  parameter int TMO_W      = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din_r,
  input  logic [DATA_WIDTH-1:0] din_f,
  input  logic [1:0]            bus_width,
  input  logic                  ddr_mode,
  input  logic [LEN_W-1:0]      blk_len,
  input  logic [TMO_W-1:0]      tmo_cycles,
  input  logic                  arm,
  input  logic                  abort,
  output logic                  busy,
  output logic [15:0]           dout,
  output logic [1:0]            dout_vld,
  output logic                  done,
  output logic                  end_err,
  output logic                  tmo_err,
  output logic                  cfg_err
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_START, S_DATA, S_CRC, S_END} state_t;

  state_t           state_q;
  logic [1:0]       bw_q;
  logic             ddr_q;
  logic [LEN_W-1:0] blk_len_q;
  logic [LEN_W-1:0] byte_cnt_q;
  logic [TMO_W-1:0] tmo_cnt_q;
  logic [4:0]       crc_cnt_q;
  logic [7:0]       sh_q;
  logic [2:0]       bit_cnt_q;
  logic             busy_q, done_q, end_err_q, tmo_err_q, cfg_err_q;
  logic [15:0]      dout_q;
  logic [1:0]       dout_vld_q;

  logic [7:0]       rx, fx, bits, lane_mask, sh_d;
  logic [3:0]       nbits, bit_sum;
  logic [LEN_W-1:0] rem;
  logic             cfg_bad, end_bad, ddr8;

  // Per-mode bit extraction: lanes are zero-extended to 8 so one datapath covers all widths.
  always_comb begin
    rx        = 8'(din_r);
    fx        = 8'(din_f);
    nbits     = 4'd8;
    bits      = rx;
    lane_mask = 8'hFF;
    case (bw_q)
      2'd0: begin
        lane_mask = 8'h01;
        if (ddr_q) begin
          nbits = 4'd2;
          bits  = {6'b0, rx[0], fx[0]};
        end else begin
          nbits = 4'd1;
          bits  = {7'b0, rx[0]};
        end
      end
      2'd1: begin
        lane_mask = 8'h0F;
        if (ddr_q) begin
          nbits = 4'd8;
          bits  = {rx[3:0], fx[3:0]};
        end else begin
          nbits = 4'd4;
          bits  = {4'b0, rx[3:0]};
        end
      end
      default: ;
    endcase
    bit_sum = {1'b0, bit_cnt_q} + nbits;
    sh_d    = (sh_q << nbits) | bits;
    rem     = blk_len_q - byte_cnt_q;
    ddr8    = (bw_q == 2'd2) && ddr_q;
    end_bad = |(~rx & lane_mask);
    cfg_bad = (bus_width == 2'd3)
           || ((bus_width == 2'd2) && (DATA_WIDTH != 8))
           || ((bus_width == 2'd1) && (DATA_WIDTH < 4))
           || (blk_len == '0);
  end

  // Transfer FSM with registered outputs; abort overrides everything else.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      bw_q       <= 2'd0;
      ddr_q      <= 1'b0;
      blk_len_q  <= '0;
      byte_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      crc_cnt_q  <= '0;
      sh_q       <= '0;
      bit_cnt_q  <= '0;
      busy_q     <= 1'b0;
      dout_q     <= '0;
      dout_vld_q <= 2'b00;
      done_q     <= 1'b0;
      end_err_q  <= 1'b0;
      tmo_err_q  <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      dout_vld_q <= 2'b00;
      done_q     <= 1'b0;
      end_err_q  <= 1'b0;
      tmo_err_q  <= 1'b0;
      cfg_err_q  <= 1'b0;
      if (abort) begin
        state_q    <= S_IDLE;
        busy_q     <= 1'b0;
        byte_cnt_q <= '0;
        tmo_cnt_q  <= '0;
        crc_cnt_q  <= '0;
        sh_q       <= '0;
        bit_cnt_q  <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (arm) begin
              if (cfg_bad) begin
                cfg_err_q <= 1'b1;
              end else begin
                bw_q       <= bus_width;
                ddr_q      <= ddr_mode;
                blk_len_q  <= blk_len;
                tmo_cnt_q  <= tmo_cycles;
                byte_cnt_q <= '0;
                sh_q       <= '0;
                bit_cnt_q  <= '0;
                busy_q     <= 1'b1;
                state_q    <= S_WAIT_START;
              end
            end
          end
          S_WAIT_START: begin
            if (!rx[0]) begin
              state_q <= S_DATA;
            end else if (tmo_cnt_q == TMO_W'(1)) begin
              tmo_err_q <= 1'b1;
              busy_q    <= 1'b0;
              tmo_cnt_q <= '0;
              state_q   <= S_IDLE;
            end else if (tmo_cnt_q != '0) begin
              tmo_cnt_q <= tmo_cnt_q - TMO_W'(1);
            end
          end
          S_DATA: begin
            if (ddr8) begin
              if (rem == LEN_W'(1)) begin
                // odd length: the falling-edge byte is past the block and is dropped
                dout_q     <= {dout_q[15:8], rx};
                dout_vld_q <= 2'b01;
                byte_cnt_q <= byte_cnt_q + LEN_W'(1);
                crc_cnt_q  <= 5'd16;
                state_q    <= S_CRC;
              end else begin
                dout_q     <= {fx, rx};
                dout_vld_q <= 2'b11;
                byte_cnt_q <= byte_cnt_q + LEN_W'(2);
                if (rem == LEN_W'(2)) begin
                  crc_cnt_q <= 5'd16;
                  state_q   <= S_CRC;
                end
              end
            end else begin
              sh_q      <= sh_d;
              bit_cnt_q <= bit_sum[2:0];
              if (bit_sum[3]) begin
                dout_q     <= {dout_q[15:8], sh_d};
                dout_vld_q <= 2'b01;
                byte_cnt_q <= byte_cnt_q + LEN_W'(1);
                if (rem == LEN_W'(1)) begin
                  crc_cnt_q <= 5'd16;
                  state_q   <= S_CRC;
                end
              end
            end
          end
          S_CRC: begin
            if (crc_cnt_q == 5'd1) begin
              state_q <= S_END;
            end
            crc_cnt_q <= crc_cnt_q - 5'd1;
          end
          S_END: begin
            done_q    <= 1'b1;
            end_err_q <= end_bad;
            busy_q    <= 1'b0;
            state_q   <= S_IDLE;
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign busy     = busy_q;
  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign done     = done_q;
  assign end_err  = end_err_q;
  assign tmo_err  = tmo_err_q;
  assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_sd_emmc_rx_deser.sv
// Directed bench for sd_emmc_rx_deser: one 8-lane instance for transfers and a
// 4-lane instance for the lane-capacity check.
module tb_sd_emmc_rx_deser;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  din_r, din_f;
  logic [1:0]  bus_width;
  logic        ddr_mode;
  logic [11:0] blk_len;
  logic [23:0] tmo_cycles;
  logic        arm, arm4, abort;

  logic        busy, done, end_err, tmo_err, cfg_err;
  logic [15:0] dout;
  logic [1:0]  dout_vld;
  logic        busy4, done4, end_err4, tmo_err4, cfg_err4;
  logic [15:0] dout4;
  logic [1:0]  dout_vld4;

  sd_emmc_rx_deser #(.DATA_WIDTH(8), .LEN_W(12), .TMO_W(24)) u_dut (
    .clk(clk), .rst(rst), .din_r(din_r), .din_f(din_f),
    .bus_width(bus_width), .ddr_mode(ddr_mode), .blk_len(blk_len),
    .tmo_cycles(tmo_cycles), .arm(arm), .abort(abort), .busy(busy),
    .dout(dout), .dout_vld(dout_vld), .done(done), .end_err(end_err),
    .tmo_err(tmo_err), .cfg_err(cfg_err)
  );

  sd_emmc_rx_deser #(.DATA_WIDTH(4), .LEN_W(12), .TMO_W(24)) u_dut4 (
    .clk(clk), .rst(rst), .din_r(din_r[3:0]), .din_f(din_f[3:0]),
    .bus_width(bus_width), .ddr_mode(ddr_mode), .blk_len(blk_len),
    .tmo_cycles(tmo_cycles), .arm(arm4), .abort(abort), .busy(busy4),
    .dout(dout4), .dout_vld(dout_vld4), .done(done4), .end_err(end_err4),
    .tmo_err(tmo_err4), .cfg_err(cfg_err4)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int cur;
  int n_cmp = 0;
  int n_err = 0;

  // Cycle index: inputs applied after posedge N belong to cycle N.
  always @(posedge clk) cyc++;

  typedef struct {
    logic [1:0]  vld;
    logic [15:0] d;
    int          c;
  } ev_t;
  typedef struct {
    logic [7:0] b;
    int         c;
  } byte_t;

  ev_t        evq[$];
  logic [7:0] tx[0:511];
  int         done_n, done_cyc, tmo_n, tmo_cyc, s_cyc;
  logic       end_err_s, busy_at_done, busy_at_tmo;

  // Output monitor, sampling mid-cycle.
  always @(negedge clk) begin
    if (dout_vld != 2'b00) evq.push_back('{dout_vld, dout, cyc});
    if (done) begin
      done_n++;
      done_cyc     = cyc;
      end_err_s    = end_err;
      busy_at_done = busy;
    end
    if (tmo_err) begin
      tmo_n++;
      tmo_cyc     = cyc;
      busy_at_tmo = busy;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  task automatic drive_cycle(input logic [7:0] r, input logic [7:0] f);
    din_r = r;
    din_f = f;
    cur   = cyc;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] unit_val(input int u, input int lanes, input int units);
    int         upb;
    logic [7:0] mask, b, v;
    upb  = 8 / lanes;
    mask = 8'((1 << lanes) - 1);
    if (u >= units) return 8'hEE;
    b = tx[u / upb];
    v = 8'(b >> (8 - lanes * ((u % upb) + 1))) & mask;
    return ~mask | v;
  endfunction

  task automatic arm_and_start(input int bw, input int ddr, input int len, input int pre);
    bus_width  = 2'(bw);
    ddr_mode   = ddr[0];
    blk_len    = 12'(len);
    tmo_cycles = 24'd1000;
    arm        = 1'b1;
    drive_cycle(8'hFF, 8'hFF);
    arm        = 1'b0;
    bus_width  = 2'd3;
    ddr_mode   = 1'b0;
    blk_len    = 12'd0;
    repeat (pre) drive_cycle(8'hFF, 8'hFF);
    drive_cycle(8'hFE, 8'hFF);
    s_cyc = cur;
  endtask

  task automatic run_xfer(input string tag, input int bw, input int ddr, input int len,
                          input logic [7:0] endv);
    int    lanes, per, units, d_cyc, errs, bad_vld, bpc;
    byte_t got[$];
    logic [7:0] mask;
    lanes = (bw == 0) ? 1 : (bw == 1) ? 4 : 8;
    per   = 1 + ddr;
    units = len * (8 / lanes);
    d_cyc = (units + per - 1) / per;
    bpc   = lanes * per;
    mask  = 8'((1 << lanes) - 1);
    evq.delete();
    done_n = 0;
    arm_and_start(bw, ddr, len, 2);
    for (int j = 0; j < d_cyc; j++)
      drive_cycle(unit_val(j * per, lanes, units),
                  (ddr != 0) ? unit_val(j * per + 1, lanes, units) : 8'hFF);
    repeat (16) drive_cycle(8'h00, 8'h00);
    drive_cycle(endv, 8'hFF);
    for (int k = 0; k < 10; k++) begin
      drive_cycle(8'hFF, 8'hFF);
      #5;
      if (done_n > 0) break;
    end
    bad_vld = 0;
    foreach (evq[i]) begin
      if (evq[i].vld == 2'b10) bad_vld++;
      if (evq[i].vld[0]) got.push_back('{evq[i].d[7:0], evq[i].c});
      if (evq[i].vld[1]) got.push_back('{evq[i].d[15:8], evq[i].c});
    end
    errs = 0;
    for (int i = 0; i < got.size() && i < len; i++)
      if (got[i].b !== tx[i] || got[i].c != s_cyc + (8 * (i + 1) + bpc - 1) / bpc + 1) errs++;
    check_eq({tag, "_nbytes"}, got.size(), len);
    check_eq({tag, "_bytes_bad"}, errs, 0);
    check_eq({tag, "_vld10"}, bad_vld, 0);
    check_eq({tag, "_done_n"}, done_n, 1);
    check_eq({tag, "_done_at"}, done_cyc - s_cyc, d_cyc + 18);
    check_eq({tag, "_end_err"}, 32'(end_err_s), 32'(|(~endv & mask)));
    check_eq({tag, "_busy_at_done"}, 32'(busy_at_done), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; arm = 1'b0; arm4 = 1'b0; abort = 1'b0;
    bus_width = 2'd0; ddr_mode = 1'b0; blk_len = 12'd1; tmo_cycles = 24'd0;
    din_r = 8'hFF; din_f = 8'hFF;
    done_n = 0; tmo_n = 0;
    repeat (3) drive_cycle(8'hFF, 8'hFF);
    rst = 1'b1;
    drive_cycle(8'hFF, 8'hFF);
    #5;
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_dout", 32'(dout), 0);
    check_eq("rst_vld", 32'(dout_vld), 0);
    check_eq("rst_pulses", 32'({done, end_err, tmo_err, cfg_err}), 0);

    // 1-bit SDR, A5 3C, good end bit
    tx[0] = 8'hA5; tx[1] = 8'h3C;
    run_xfer("sdr1", 0, 0, 2, 8'hFF);
    check_eq("sdr1_nev", evq.size(), 2);
    if (evq.size() >= 2) begin
      check_eq("sdr1_first_at", evq[0].c - s_cyc, 9);
      check_eq("sdr1_spacing", evq[1].c - evq[0].c, 8);
    end

    // 4-bit DDR, 512 incrementing bytes
    for (int i = 0; i < 512; i++) tx[i] = 8'(i);
    run_xfer("ddr4", 1, 1, 512, 8'hFF);

    // 8-bit DDR odd length
    tx[0] = 8'h11; tx[1] = 8'h22; tx[2] = 8'h33;
    run_xfer("ddr8", 2, 1, 3, 8'hFF);
    check_eq("ddr8_nev", evq.size(), 2);
    if (evq.size() >= 2) begin
      check_eq("ddr8_w0", 32'(evq[0].d), 32'h2211);
      check_eq("ddr8_v0", 32'(evq[0].vld), 2'b11);
      check_eq("ddr8_v1", 32'(evq[1].vld), 2'b01);
      check_eq("ddr8_b2", 32'(evq[1].d[7:0]), 32'h33);
    end

    // end bit on lane 2 low: error in 4-bit mode, ignored in 1-bit mode
    tx[0] = 8'h9C; tx[1] = 8'h01; tx[2] = 8'hF0;
    run_xfer("sdr4_endbad", 1, 0, 3, 8'hFB);
    run_xfer("sdr1_lane2", 0, 0, 1, 8'hFB);
    tx[0] = 8'h6B; tx[1] = 8'hD2;
    run_xfer("ddr1", 0, 1, 2, 8'hFF);
    tx[0] = 8'h01; tx[1] = 8'h80; tx[2] = 8'hFE; tx[3] = 8'h7F;
    run_xfer("sdr8", 2, 0, 4, 8'hFF);
    run_xfer("ddr8_endbad", 2, 1, 4, 8'h7F);

    // timeout of 100 cycles
    tmo_n = 0;
    bus_width = 2'd0; ddr_mode = 1'b0; blk_len = 12'd4; tmo_cycles = 24'd100;
    arm = 1'b1;
    drive_cycle(8'hFF, 8'hFF);
    arm = 1'b0;
    s_cyc = cur;
    #5;
    check_eq("tmo_busy_t1", 32'(busy), 1);
    for (int k = 0; k < 200; k++) begin
      drive_cycle(8'hFF, 8'hFF);
      #5;
      if (tmo_n > 0) break;
    end
    check_eq("tmo_n", tmo_n, 1);
    check_eq("tmo_at", tmo_cyc - s_cyc, 101);
    check_eq("tmo_busy", 32'(busy_at_tmo), 0);

    // timeout disabled
    tmo_n = 0;
    tmo_cycles = 24'd0;
    arm = 1'b1;
    drive_cycle(8'hFF, 8'hFF);
    arm = 1'b0;
    repeat (300) drive_cycle(8'hFF, 8'hFF);
    #5;
    check_eq("notmo_n", tmo_n, 0);
    check_eq("notmo_busy", 32'(busy), 1);
    abort = 1'b1;
    drive_cycle(8'hFF, 8'hFF);
    abort = 1'b0;
    #5;
    check_eq("notmo_abort_busy", 32'(busy), 0);

    // configuration rejects
    bus_width = 2'd2; ddr_mode = 1'b0; blk_len = 12'd5;
    arm4 = 1'b1;
    drive_cycle(8'hFF, 8'hFF);
    arm4 = 1'b0;
    #5;
    check_eq("cfg4_err", 32'(cfg_err4), 1);
    check_eq("cfg4_busy", 32'(busy4), 0);
    drive_cycle(8'hFF, 8'hFF);
    #5;
    check_eq("cfg4_pulse", 32'(cfg_err4), 0);
    bus_width = 2'd1;
    arm4 = 1'b1;
    drive_cycle(8'hFF, 8'hFF);
    arm4 = 1'b0;
    #5;
    check_eq("cfg4_ok_busy", 32'(busy4), 1);
    check_eq("cfg4_ok_err", 32'(cfg_err4), 0);
    bus_width = 2'd3;
    arm = 1'b1;
    drive_cycle(8'hFF, 8'hFF);
    arm = 1'b0;
    #5;
    check_eq("cfg_bw3_err", 32'(cfg_err), 1);
    check_eq("cfg_bw3_busy", 32'(busy), 0);
    bus_width = 2'd0; blk_len = 12'd0;
    arm = 1'b1;
    drive_cycle(8'hFF, 8'hFF);
    arm = 1'b0;
    #5;
    check_eq("cfg_len0_err", 32'(cfg_err), 1);
    check_eq("cfg_len0_busy", 32'(busy), 0);
    abort = 1'b1;
    drive_cycle(8'hFF, 8'hFF);
    abort = 1'b0;
    #5;
    check_eq("abort4_busy", 32'(busy4), 0);

    // abort mid-DATA
    evq.delete(); done_n = 0;
    arm_and_start(0, 0, 4, 1);
    repeat (5) drive_cycle(8'h00, 8'h00);
    abort = 1'b1; arm = 1'b1;
    drive_cycle(8'h00, 8'h00);
    abort = 1'b0; arm = 1'b0;
    #5;
    check_eq("abort_busy", 32'(busy), 0);
    repeat (40) drive_cycle(8'hFF, 8'hFF);
    check_eq("abort_done_n", done_n, 0);
    check_eq("abort_nev", evq.size(), 0);
    tx[0] = 8'hC3; tx[1] = 8'h5A;
    run_xfer("after_abort", 1, 1, 2, 8'hFF);

    // reset mid-DATA
    arm_and_start(2, 0, 8, 0);
    repeat (3) drive_cycle(8'h5A, 8'hFF);
    done_n = 0;
    rst = 1'b0;
    drive_cycle(8'hFF, 8'hFF);
    rst = 1'b1;
    #5;
    check_eq("rstmid_busy", 32'(busy), 0);
    check_eq("rstmid_dout", 32'(dout), 0);
    check_eq("rstmid_vld", 32'(dout_vld), 0);
    repeat (30) drive_cycle(8'hFF, 8'hFF);
    check_eq("rstmid_done_n", done_n, 0);
    tx[0] = 8'h12; tx[1] = 8'h34; tx[2] = 8'h56; tx[3] = 8'h78;
    run_xfer("after_rst", 2, 0, 4, 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
